// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core.
// Holds the MEM/WB bundle layout and load funct3 encodings.
package core_pkg;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // result_src kept as raw bits: code 11 is reserved but must decode
   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic [1:0]  result_src;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [1:0]  offset;
      logic [31:0] alu_result;
      logic [31:0] read_data;
      logic [31:0] pc_plus4;
   } mem_wb_t;

endpackage

// File: rtl/load_extend.sv
// Load byte/halfword extraction with sign/zero extension.
// Purely combinational; shared with the LSU.
module load_extend
   import core_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] word_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{offset_i, 3'b000} +: 8];
      half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      data_o = word_i;
      case (funct3_i)
         F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  data_o = {24'h0, byte_sel};
         F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  data_o = {16'h0, half_sel};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback mux, load-store forwarding
// select and retired-instruction counter.
module mem_wb_stage
   import core_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic             valid_m_i,
   input  logic             reg_write_m_i,
   input  logic [1:0]       result_src_m_i,
   input  logic [4:0]       rd_m_i,
   input  logic [4:0]       rs2_m_i,
   input  logic             mem_write_m_i,
   input  logic [2:0]       funct3_m_i,
   input  logic [WIDTH-1:0] alu_result_m_i,
   input  logic [WIDTH-1:0] read_data_m_i,
   input  logic [WIDTH-1:0] pc_plus4_m_i,
   output logic             reg_write_w_o,
   output logic [4:0]       rd_w_o,
   output logic [WIDTH-1:0] result_w_o,
   output logic             fwd_ls_w_o,
   output logic [CNT_W-1:0] instret_o
);

   mem_wb_t          wb_q, wb_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [31:0]      load_data;
   logic             wr_ok;

   always_comb begin
      wb_d = wb_q;
      if (flush_i) begin
         wb_d.valid     = 1'b0;
         wb_d.reg_write = 1'b0;
      end else if (!stall_i) begin
         wb_d.valid      = valid_m_i;
         wb_d.reg_write  = reg_write_m_i & valid_m_i;
         wb_d.result_src = result_src_m_i;
         wb_d.rd         = rd_m_i;
         wb_d.funct3     = funct3_m_i;
         wb_d.offset     = alu_result_m_i[1:0];
         wb_d.alu_result = alu_result_m_i;
         wb_d.read_data  = read_data_m_i;
         wb_d.pc_plus4   = pc_plus4_m_i;
      end
   end

   // The retiring instruction counts even if the incoming one is flushed
   always_comb begin
      instret_d = instret_q;
      if (wb_q.valid && !stall_i) begin
         instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_q      <= '0;
         instret_q <= '0;
      end else begin
         wb_q      <= wb_d;
         instret_q <= instret_d;
      end
   end

   load_extend u_load_extend (
      .funct3_i (wb_q.funct3),
      .offset_i (wb_q.offset),
      .word_i   (wb_q.read_data),
      .data_o   (load_data)
   );

   always_comb begin
      result_w_o = wb_q.alu_result;
      case (wb_q.result_src)
         RES_MEM: result_w_o = load_data;
         RES_PC4: result_w_o = wb_q.pc_plus4;
         default: result_w_o = wb_q.alu_result;
      endcase
   end

   assign wr_ok = wb_q.valid & wb_q.reg_write & (wb_q.rd != 5'd0);

   assign reg_write_w_o = wr_ok;
   assign rd_w_o        = wb_q.rd;
   assign instret_o     = instret_q;

   assign fwd_ls_w_o = wr_ok
                     & (wb_q.result_src == RES_MEM)
                     & mem_write_m_i & valid_m_i
                     & (rs2_m_i == wb_q.rd);

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register plus writeback logic for the 5-stage RV32I core. Captures memory-stage outputs on each clock. Performs load byte/halfword extraction and sign/zero extension, then selects the writeback result. Drives the register file write port and produces the load-to-store forwarding select (fwd_ls_w) and result_w consumed by the memory stage. Also keeps a retired-instruction counter.

Parameters:
WIDTH, 32, datapath width; only 32 is supported.
CNT_W, 64, width of the retired-instruction counter.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
stall_i  input  1  hold all WB registers and the counter.
flush_i  input  1  invalidate the instruction entering WB.
valid_m_i  input  1  M stage holds a real instruction.
reg_write_m_i  input  1  M-stage instruction writes rd.
result_src_m_i  input  2  00 ALU, 01 load data, 10 pc+4, 11 reserved.
rd_m_i  input  5  destination register.
rs2_m_i  input  5  store-data source register of the M-stage instruction.
mem_write_m_i  input  1  M-stage instruction is a store.
funct3_m_i  input  3  load width/sign encoding.
alu_result_m_i  input  WIDTH  ALU result, also the memory address.
read_data_m_i  input  WIDTH  word read from data RAM (combinational in M).
pc_plus4_m_i  input  WIDTH  pc+4 of the M-stage instruction.
reg_write_w_o  output  1  register file write enable.
rd_w_o  output  5  register file write address.
result_w_o  output  WIDTH  register file write data; also the forwarding value.
fwd_ls_w_o  output  1  memory stage selects result_w as store data.
instret_o  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, rst_n=0): all WB registers are 0, valid_w=0, instret=0. Outputs: reg_write_w_o=0, rd_w_o=0, result_w_o=0, fwd_ls_w_o=0, instret_o=0. Release is synchronous to clk through the normal flop path.
- Registered fields: valid, reg_write, result_src, rd, funct3, byte offset (alu_result[1:0]), alu_result, read_data, pc_plus4.
- Update priority each edge:
  1. flush_i=1: valid_w<=0, reg_write_w<=0; other fields don't-care. Flush wins over stall.
  2. stall_i=1: every register holds.
  3. Otherwise: capture the M inputs. valid_w<=valid_m_i. reg_write_w<=reg_write_m_i & valid_m_i.
- Latency: one cycle from M inputs to WB outputs. result_w_o is combinational from the WB registers.
- Load extraction uses the registered offset:
  - funct3 000 LB: sign-extend byte[offset].
  - funct3 100 LBU: zero-extend byte[offset].
  - funct3 001 LH: sign-extend halfword[offset[1]].
  - funct3 101 LHU: zero-extend halfword[offset[1]].
  - funct3 010 LW and all other codes: full word.
  - offset[0] is ignored for halfwords; misalignment trapping is out of scope.
- Result mux: 00 alu_result, 01 extended load, 10 pc_plus4, 11 alu_result.
- reg_write_w_o = reg_write_w & valid_w & (rd_w != 0). Writes to x0 are suppressed here.
- fwd_ls_w_o = valid_w & reg_write_w & (rd_w!=0) & (result_src_w==01) & mem_write_m_i & valid_m_i & (rs2_m_i==rd_w). This covers load followed immediately by a dependent store. It is combinational from WB state and M inputs.
- instret increments by 1 on each edge where valid_w=1 and stall_i=0. It wraps modulo 2^CNT_W. It is unaffected by flush_i in that cycle, because flush acts on the incoming instruction, not the retiring one.
- Reset asserted mid-operation clears all state immediately. No partial write may occur: reg_write_w_o drops combinationally with rst_n.

Decomposition:
- Shared package core_pkg holds:
  - result_src_e enum: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10.
  - funct3 load constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - mem_wb_t packed struct for the registered fields.
- One sub-module: load_extend. It is purely combinational (funct3, offset, word -> extended data) and is reused by the future LSU.

Test Plan:
- Reset then ALU op: M presents rd=5, alu=0x0000_1234, src=00, valid=1 -> next cycle reg_write_w_o=1, rd_w_o=5, result_w_o=0x0000_1234, instret_o=1 one edge later.
- Load extension: read_data=0x80FF_7F01, alu[1:0]=2.
  - LB -> 0xFFFF_FFFF.
  - LBU -> 0x0000_00FF.
  - LH -> 0xFFFF_80FF.
  - LHU -> 0x0000_80FF.
  - offset 1, LB -> 0x0000_007F.
- Load-store forwarding: WB holds LW rd=7 with data 0xDEAD_BEEF; M holds SW rs2=7 valid -> fwd_ls_w_o=1, result_w_o=0xDEAD_BEEF. Repeat with rs2=8, rd=0, or WB src=00 -> fwd_ls_w_o=0.
- Stall/flush: stall for 3 cycles -> outputs frozen, instret frozen. stall+flush same edge -> valid_w=0, reg_write_w_o=0.
- x0 and bubbles: rd=0 with reg_write=1 -> reg_write_w_o=0. valid_m_i=0 -> no write, instret unchanged.
- Async reset mid-stream: drop rst_n between edges while reg_write_w_o=1 -> all outputs 0 immediately. instret 0xFFFF_FFFF_FFFF_FFFF plus one retire -> 0.
